lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl_if.sv | 33 +++
 rtl/lsu_mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl_if
// Description : Core-side request/response bundle of the load/store front-end.
//               master = core (drives requests), slave = lsu_mem_ctrl.
//   req_valid_i/req_ready_o : request handshake
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i : fields
//   rsp_valid_o, rsp_rdata_o, rsp_err_o : one-cycle response
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store front-end for a 4 x 8-bit byte-lane data RAM with
//               1-cycle synchronous read. One request at a time; misaligned
//               half/word accesses are split into two word accesses; load data
//               is merged, shifted and sign/zero-extended.
//   clk, rst    : clock, synchronous active-high reset
//   core        : request/response bundle (slave side)
//   ram_wen_o   : byte write enables      ram_waddr_o : write byte address
//   ram_wdata_o : lane-aligned write data ram_ren_o   : read enable
//   ram_raddr_o : read byte address       ram_rdata_i : read data (next cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 14
) (
    input  wire logic        clk,
    input  wire logic        rst,
    lsu_mem_ctrl_if.slave    core,
    output logic [3:0]       ram_wen_o,
    output logic [31:0]      ram_waddr_o,
    output logic [31:0]      ram_wdata_o,
    output logic             ram_ren_o,
    output logic [31:0]      ram_raddr_o,
    input  wire logic [31:0] ram_rdata_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC1 = 3'd1;
    localparam logic [2:0] S_ACC2 = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]  r_state, w_next;
    logic        r_we, r_unsigned, r_split, r_err;
    logic [1:0]  r_size, r_off_lo;
    logic [31:0] r_wdata, r_lo, r_hi, r_ram_addr;

    // ---------------- request decode (IDLE cycle, straight from the bus) ----
    logic [31:0] w_off;
    logic [2:0]  w_nbytes;
    logic        w_split, w_err, w_accept;
    logic [31:0] w_first_addr;

    assign w_off    = core.req_addr_i - BASE_ADDR;
    assign w_nbytes = (core.req_size_i == 2'd0) ? 3'd1 :
                      (core.req_size_i == 2'd1) ? 3'd2 : 3'd4;
    assign w_split  = ({1'b0, w_off[1:0]} + w_nbytes) > 3'd4;
    // A split access whose first word is the top word would wrap: reject it.
    assign w_err    = (|w_off[31:ADDR_W]) || (core.req_size_i == 2'd3) ||
                      (w_split && (&w_off[ADDR_W-1:2]));
    assign w_accept = core.req_valid_i && (r_state == S_IDLE);
    assign w_first_addr = BASE_ADDR + {{(32-ADDR_W){1'b0}}, w_off[ADDR_W-1:2], 2'b00};

    // ---------------- lane math on the captured request ---------------------
    logic [7:0]  w_mask_base, w_mask;
    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [31:0] w_aligned, w_load;

    assign w_mask_base = (r_size == 2'd0) ? 8'h01 :
                         (r_size == 2'd1) ? 8'h03 : 8'h0F;
    assign w_mask      = w_mask_base << r_off_lo;
    assign w_shamt     = {1'b0, r_off_lo, 3'b000};
    assign w_shifted   = {32'b0, r_wdata} << w_shamt;
    // r_hi stays zero for non-split loads, so one shifter serves both cases.
    assign w_aligned   = 32'({r_hi, r_lo} >> w_shamt);

    always_comb begin
        w_load = w_aligned;
        case (r_size)
            2'd0:    w_load = r_unsigned ? {24'b0, w_aligned[7:0]}
                                         : {{24{w_aligned[7]}}, w_aligned[7:0]};
            2'd1:    w_load = r_unsigned ? {16'b0, w_aligned[15:0]}
                                         : {{16{w_aligned[15]}}, w_aligned[15:0]};
            default: w_load = w_aligned;
        endcase
    end

    // ---------------- state register ----------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- capture / datapath registers --------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off_lo   <= 2'd0;
            r_wdata    <= 32'd0;
            r_split    <= 1'b0;
            r_err      <= 1'b0;
            r_lo       <= 32'd0;
            r_hi       <= 32'd0;
            r_ram_addr <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_we       <= core.req_we_i;
                    r_size     <= core.req_size_i;
                    r_unsigned <= core.req_unsigned_i;
                    r_off_lo   <= w_off[1:0];
                    r_wdata    <= core.req_wdata_i;
                    r_split    <= w_split;
                    r_err      <= w_err;
                    r_lo       <= 32'd0;
                    r_hi       <= 32'd0;
                    // Faulting requests leave the RAM address untouched.
                    if (!w_err) r_ram_addr <= w_first_addr;
                end
                S_ACC1: if (r_split) r_ram_addr <= r_ram_addr + 32'd4;
                S_ACC2: if (!r_we) r_lo <= ram_rdata_i;
                S_WAIT: begin
                    if (r_split) r_hi <= ram_rdata_i;
                    else         r_lo <= ram_rdata_i;
                end
                default: ;
            endcase
        end
    end

    // ---------------- next state and outputs --------------------------------
    assign core.req_ready_o = (r_state == S_IDLE);
    assign ram_waddr_o      = r_ram_addr;
    assign ram_raddr_o      = r_ram_addr;

    always_comb begin
        w_next           = r_state;
        ram_wen_o        = 4'b0;
        ram_ren_o        = 1'b0;
        ram_wdata_o      = 32'd0;
        core.rsp_valid_o = 1'b0;
        core.rsp_err_o   = 1'b0;
        core.rsp_rdata_o = 32'd0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_err ? S_RESP : S_ACC1;
            S_ACC1: begin
                if (r_we) begin
                    ram_wen_o   = w_mask[3:0];
                    ram_wdata_o = w_shifted[31:0];
                    w_next      = r_split ? S_ACC2 : S_RESP;
                end else begin
                    ram_ren_o = 1'b1;
                    w_next    = r_split ? S_ACC2 : S_WAIT;
                end
            end
            S_ACC2: begin
                if (r_we) begin
                    ram_wen_o   = w_mask[7:4];
                    ram_wdata_o = w_shifted[63:32];
                    w_next      = S_RESP;
                end else begin
                    ram_ren_o = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: w_next = S_RESP;
            S_RESP: begin
                core.rsp_valid_o = 1'b1;
                core.rsp_err_o   = r_err;
                core.rsp_rdata_o = (!r_we && !r_err) ? w_load : 32'd0;
                w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset aborts an access immediately: nothing reaches the RAM or core.
        if (rst) begin
            ram_wen_o        = 4'b0;
            ram_ren_o        = 1'b0;
            ram_wdata_o      = 32'd0;
            core.rsp_valid_o = 1'b0;
            core.rsp_err_o   = 1'b0;
            core.rsp_rdata_o = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed self-checking bench for lsu_mem_ctrl with a byte-lane
//               RAM model (4096 words, 1-cycle synchronous read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if ifc ();

    logic [3:0]  ram_wen;
    logic [31:0] ram_waddr, ram_wdata, ram_raddr;
    logic [31:0] ram_rdata = 32'd0;
    logic        ram_ren;

    lsu_mem_ctrl #(.BASE_ADDR(32'h0000_0000), .ADDR_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .core        (ifc.slave),
        .ram_wen_o   (ram_wen),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_ren_o   (ram_ren),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata)
    );

    // Byte-lane RAM model
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_waddr[13:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_ren) ram_rdata <= mem[ram_raddr[13:2]];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-transaction observations
    int          lat, nw, nr, nrsp, first_ren;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [3:0]  w_en   [2];
    logic [31:0] w_addr [2];
    logic [31:0] w_data [2];
    logic [31:0] r_addr [2];

    // Presents one request from IDLE and watches until the cycle after rsp.
    // Cycle numbers are relative to the accept cycle T (cycle 1 = T+1).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ifc.req_we_i       = we;
        ifc.req_size_i     = size;
        ifc.req_unsigned_i = uns;
        ifc.req_addr_i     = addr;
        ifc.req_wdata_i    = wdata;
        ifc.req_valid_i    = 1'b1;
        lat = 0; nw = 0; nr = 0; nrsp = 0; first_ren = 0;
        got_rdata = 32'd0; got_err = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            ifc.req_valid_i = 1'b0;
            if (|ram_wen) begin
                if (nw < 2) begin
                    w_en[nw] = ram_wen; w_addr[nw] = ram_waddr; w_data[nw] = ram_wdata;
                end
                nw++;
            end
            if (ram_ren) begin
                if (nr == 0) first_ren = c;
                if (nr < 2) r_addr[nr] = ram_raddr;
                nr++;
            end
            if (ifc.rsp_valid_o) begin
                nrsp++;
                if (lat == 0) begin
                    lat = c; got_rdata = ifc.rsp_rdata_o; got_err = ifc.rsp_err_o;
                end
            end else if (lat != 0) begin
                break;
            end
        end
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp, input int exp_lat);
        issue(1'b0, size, uns, addr, 32'd0);
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_rdata"}, got_rdata, exp);
        check({tag, "_err"},   {31'd0, got_err}, 32'd0);
        check({tag, "_width"}, nrsp, 1);
    endtask

    // Back-to-back bookkeeping
    int          acc_c [3];
    int          rsp_c [3];
    logic [31:0] rsp_d [3];
    logic [31:0] b2b_addr [3];
    int          na, nrs;

    initial begin
        ifc.req_valid_i    = 1'b0;
        ifc.req_we_i       = 1'b0;
        ifc.req_size_i     = 2'd0;
        ifc.req_unsigned_i = 1'b0;
        ifc.req_addr_i     = 32'd0;
        ifc.req_wdata_i    = 32'd0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        check("rst_ready", {31'd0, ifc.req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'd0, ifc.rsp_valid_o}, 32'd0);
        check("rst_enables", {27'd0, ram_wen, ram_ren}, 32'd0);
        check("rst_waddr", ram_waddr, 32'd0);
        rst = 1'b0;

        // ---- reset in the middle of a load ----
        ifc.req_size_i  = 2'd2;
        ifc.req_addr_i  = 32'h10;
        ifc.req_valid_i = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid_i = 1'b0;
        check("midrst_ren_acc1", {31'd0, ram_ren}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ren_drop", {31'd0, ram_ren}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("midrst_quiet", {26'd0, ifc.rsp_valid_o, ram_wen, ram_ren}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", {31'd0, ifc.req_ready_o}, 32'd1);
        check("midrst_no_rsp", {31'd0, ifc.rsp_valid_o}, 32'd0);

        // ---- aligned word store / load ----
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_lat", lat, 2);
        check("sw_nw", nw, 1);
        check("sw_wen", {28'd0, w_en[0]}, 32'hF);
        check("sw_waddr", w_addr[0], 32'h10);
        check("sw_wdata", w_data[0], 32'hDEADBEEF);
        check("sw_rdata0", got_rdata, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        check("lw_ren_cycle", first_ren, 1);
        check("lw_raddr", r_addr[0], 32'h10);
        check("lw_lat", lat, 3);
        check("lw_rdata", got_rdata, 32'hDEADBEEF);
        check("lw_err", {31'd0, got_err}, 32'd0);

        // ---- byte/half extension ----
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h8081F0F1);
        check("sw20_lat", lat, 2);
        load_chk("lb23",  2'd0, 1'b0, 32'h23, 32'hFFFFFF80, 3);
        load_chk("lbu23", 2'd0, 1'b1, 32'h23, 32'h00000080, 3);
        load_chk("lh20",  2'd1, 1'b0, 32'h20, 32'hFFFFF0F1, 3);
        load_chk("lhu22", 2'd1, 1'b1, 32'h22, 32'h00008081, 3);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        check("sb_lat", lat, 2);
        check("sb_wen", {28'd0, w_en[0]}, 32'h2);
        check("sb_lane1", {24'd0, w_data[0][15:8]}, 32'hAA);
        check("sb_waddr", w_addr[0], 32'h20);
        load_chk("lw20_after_sb", 2'd2, 1'b0, 32'h20, 32'h8081AAF1, 3);

        // ---- misaligned split ----
        issue(1'b1, 2'd2, 1'b0, 32'h33, 32'h11223344);
        check("ssw_lat", lat, 3);
        check("ssw_nw", nw, 2);
        check("ssw_wen1", {28'd0, w_en[0]}, 32'h8);
        check("ssw_addr1", w_addr[0], 32'h30);
        check("ssw_lane3", {24'd0, w_data[0][31:24]}, 32'h44);
        check("ssw_wen2", {28'd0, w_en[1]}, 32'h7);
        check("ssw_addr2", w_addr[1], 32'h34);
        check("ssw_lanes012", {8'd0, w_data[1][23:0]}, 32'h112233);
        issue(1'b0, 2'd2, 1'b0, 32'h33, 32'd0);
        check("slw_nr", nr, 2);
        check("slw_raddr1", r_addr[0], 32'h30);
        check("slw_raddr2", r_addr[1], 32'h34);
        check("slw_lat", lat, 4);
        check("slw_rdata", got_rdata, 32'h11223344);
        load_chk("slh33", 2'd1, 1'b0, 32'h33, 32'h00003344, 4);

        // ---- errors ----
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
        check("err_size_lat", lat, 1);
        check("err_size_err", {31'd0, got_err}, 32'd1);
        check("err_size_ram", nw + nr, 0);
        check("err_size_rdata", got_rdata, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h4000, 32'd0);
        check("err_range_lat", lat, 1);
        check("err_range_err", {31'd0, got_err}, 32'd1);
        issue(1'b1, 2'd0, 1'b0, 32'h4000, 32'h55);
        check("err_range_st", {31'd0, got_err}, 32'd1);
        check("err_range_st_ram", nw + nr, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h3FFE, 32'd0);
        check("err_wrap_lat", lat, 1);
        check("err_wrap_err", {31'd0, got_err}, 32'd1);
        check("err_wrap_ram", nw + nr, 0);
        load_chk("lh_top_ok", 2'd1, 1'b0, 32'h3FFE, 32'd0, 3);
        check("lh_top_raddr", r_addr[0], 32'h3FFC);

        // ---- back-to-back aligned loads, valid held high ----
        b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h30;
        na = 0; nrs = 0;
        ifc.req_we_i    = 1'b0;
        ifc.req_size_i  = 2'd2;
        ifc.req_addr_i  = b2b_addr[0];
        ifc.req_valid_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            automatic logic took = 1'b0;
            if (ifc.rsp_valid_o) begin
                if (nrs < 3) begin rsp_c[nrs] = c; rsp_d[nrs] = ifc.rsp_rdata_o; end
                nrs++;
            end
            if (ifc.req_ready_o && ifc.req_valid_i) begin
                if (na < 3) acc_c[na] = c;
                na++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                if (na < 3) ifc.req_addr_i = b2b_addr[na];
                else        ifc.req_valid_i = 1'b0;
            end
        end
        ifc.req_valid_i = 1'b0;
        check("b2b_accepts", na, 3);
        check("b2b_rsps", nrs, 3);
        check("b2b_acc_gap1", acc_c[1] - acc_c[0], 4);
        check("b2b_acc_gap2", acc_c[2] - acc_c[1], 4);
        check("b2b_lat0", rsp_c[0] - acc_c[0], 3);
        check("b2b_lat2", rsp_c[2] - acc_c[2], 3);
        check("b2b_d0", rsp_d[0], 32'h8081AAF1 ^ 32'h8081AAF1 ^ 32'hDEADBEEF);
        check("b2b_d1", rsp_d[1], 32'h8081AAF1);
        check("b2b_d2", rsp_d[2], 32'h44000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
